// File: rtl/my_uart_rx.sv
`timescale 1ns/1ps
// my_uart_rx -- 8N1 UART receiver (start 0, 8 data bits LSB first, stop 1).
//
// Oversamples the asynchronous serial line, samples each bit at its centre
// and hands the received byte to the consumer with a valid/ack handshake.
// Framing errors and overruns are reported as one-cycle pulses.
//
// Ports
//   clk_i        system clock, all logic on posedge
//   rstn_i       synchronous active-low reset
//   rxd_i        serial input, asynchronous, idles high
//   rx_data_o    last received byte
//   rx_valid_o   rx_data_o holds an unconsumed byte
//   rx_ack_i     consumer accepts rx_data_o (only looked at while rx_valid_o=1)
//   rx_busy_o    frame reception in progress
//   frame_err_o  1-cycle pulse: stop bit sampled low, byte discarded
//   overrun_o    1-cycle pulse: new byte replaced an unconsumed one
module my_uart_rx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       rxd_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ack_i,
  output logic       rx_busy_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TC_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [TC_W-1:0]  TC_HALF  = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Synchronizer and edge history; preset high so reset release is not a start edge.
  logic             rxd_meta_q, rxd_s_q, rxd_prev_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_s, fall_s;

  state_t           state_q, state_d;
  logic [TC_W-1:0]  tc_q, tc_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             stop_done_s, stop_ok_s;

  logic             deliver_q, deliver_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  assign tick_s = (div_q == DIV_LAST);
  assign fall_s = rxd_prev_q & ~rxd_s_q;
  assign div_d  = tick_s ? '0 : div_q + DIV_W'(1);

  // Frame FSM next state: tc counts oversample ticks within the current bit.
  always_comb begin
    state_d     = state_q;
    tc_d        = tc_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    stop_done_s = 1'b0;
    stop_ok_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_s) begin
          state_d = START;
          tc_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          if (tc_q == TC_HALF) begin
            // Mid start bit: a line back high was only a glitch.
            if (!rxd_s_q) begin
              state_d = DATA;
              tc_d    = '0;
              bit_d   = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tc_d = tc_q + TC_W'(1);
          end
        end else begin
          tc_d = tc_q;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (tc_q == TC_LAST) begin
            shreg_d = {rxd_s_q, shreg_q[7:1]};
            tc_d    = '0;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = STOP;
            end else begin
              state_d = DATA;
            end
          end else begin
            tc_d = tc_q + TC_W'(1);
          end
        end else begin
          tc_d = tc_q;
        end
      end
      STOP: begin
        if (tick_s) begin
          if (tc_q == TC_LAST) begin
            // Leaving at mid stop bit lets the next start edge follow immediately.
            stop_done_s = 1'b1;
            stop_ok_s   = rxd_s_q;
            state_d     = IDLE;
            tc_d        = '0;
          end else begin
            tc_d = tc_q + TC_W'(1);
          end
        end else begin
          tc_d = tc_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign deliver_d   = stop_done_s & stop_ok_s;
  assign frame_err_d = stop_done_s & ~stop_ok_s;

  // Delivery and handshake: a delivery always loads the new byte; an unacked old byte is lost.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (deliver_q) begin
      rx_data_d  = shreg_q;
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q & ~rx_ack_i;
    end else if (rx_valid_q && rx_ack_i) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // All state registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      rxd_prev_q  <= 1'b1;
      div_q       <= '0;
      state_q     <= IDLE;
      tc_q        <= '0;
      bit_q       <= 3'd0;
      shreg_q     <= 8'h00;
      deliver_q   <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rxd_meta_q  <= rxd_i;
      rxd_s_q     <= rxd_meta_q;
      rxd_prev_q  <= rxd_s_q;
      div_q       <= div_d;
      state_q     <= state_d;
      tc_q        <= tc_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      deliver_q   <= deliver_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_busy_o   = (state_q != IDLE);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_my_uart_rx.sv
`timescale 1ns/1ps
// tb_my_uart_rx -- directed scoreboard bench for my_uart_rx.
// The line rate is chosen so one bit is exactly 128 clocks (DIV=8), which
// keeps the run short while exercising the same frame timing.
module tb_my_uart_rx;

  localparam int unsigned CLK_FREQ   = 100_000_000;
  localparam int unsigned BAUD_RATE  = 781_250;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int          BIT        = CLK_FREQ / BAUD_RATE;
  localparam int          GLITCH     = BIT / 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun;

  int         n_vec = 0;
  int         n_mis = 0;
  int         ferr_hi = 0;
  int         ovr_hi = 0;
  logic [7:0] exp_q[$];

  my_uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .rxd_i      (rxd),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ack_i   (ack),
    .rx_busy_o  (rx_busy),
    .frame_err_o(frame_err),
    .overrun_o  (overrun)
  );

  always #5 clk = ~clk;

  // Count cycles each error pulse is high, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_hi <= ferr_hi + 1;
    if (overrun === 1'b1) ovr_hi <= ovr_hi + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Drive start + 8 data bits, leave the line at the stop level and return.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) exp_q.push_back(b);
    rxd = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cyc(BIT);
    end
    rxd = stop;
  endtask

  // Wait (bounded) for a delivery and compare against the scoreboard head.
  task automatic recv(input string tag);
    int w;
    logic [7:0] e;
    w = 0;
    while (rx_valid !== 1'b1 && w < BIT) begin
      cyc(1);
      w++;
    end
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check({tag, "_data"}, 32'(rx_data), 32'(e));
  endtask

  task automatic do_ack(input string tag);
    check({tag, "_vpre"}, 32'(rx_valid), 32'd1);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    check({tag, "_vpost"}, 32'(rx_valid), 32'd0);
  endtask

  initial begin
    int f0, o0, w;
    logic stay, seen;
    logic [7:0] t6 [3];
    t6[0] = 8'h00; t6[1] = 8'hFF; t6[2] = 8'h80;

    // Reset state
    cyc(3);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    rstn = 1'b1;
    cyc(BIT);

    // T1: 0xA5, ack 5 cycles after valid
    send_frame(8'hA5, 1'b1);
    recv("t1");
    stay = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (rx_valid !== 1'b1 || rx_data !== 8'hA5) stay = 1'b0;
    end
    check("t1_hold", 32'(stay), 32'd1);
    do_ack("t1");
    cyc(BIT);
    check("t1_ferr", 32'(ferr_hi), 32'd0);
    check("t1_ovr", 32'(ovr_hi), 32'd0);

    // T2: short low glitch on an idle line
    f0 = ferr_hi;
    rxd = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < GLITCH; i++) begin
      cyc(1);
      if (rx_busy === 1'b1) seen = 1'b1;
    end
    rxd = 1'b1;
    check("t2_busy_seen", 32'(seen), 32'd1);
    cyc(2 * BIT);
    check("t2_busy_idle", 32'(rx_busy), 32'd0);
    check("t2_valid", 32'(rx_valid), 32'd0);
    check("t2_ferr", 32'(ferr_hi - f0), 32'd0);

    // T3: 0x3C with a low stop bit, then a clean 0x3C
    f0 = ferr_hi;
    send_frame(8'h3C, 1'b0);
    w = 0;
    while (ferr_hi == f0 && w < BIT) begin
      cyc(1);
      w++;
    end
    rxd = 1'b1;
    cyc(BIT);
    check("t3_ferr_pulse", 32'(ferr_hi - f0), 32'd1);
    check("t3_valid", 32'(rx_valid), 32'd0);
    send_frame(8'h3C, 1'b1);
    recv("t3b");
    do_ack("t3b");
    cyc(BIT);

    // T4: 0x11 then 0x22 back-to-back, no ack
    o0 = ovr_hi;
    send_frame(8'h11, 1'b1);
    cyc(BIT);
    send_frame(8'h22, 1'b1);
    w = 0;
    while (ovr_hi == o0 && w < BIT) begin
      cyc(1);
      w++;
    end
    cyc(BIT);
    check("t4_ovr_pulse", 32'(ovr_hi - o0), 32'd1);
    // The first byte was overwritten by the overrun.
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    recv("t4");
    do_ack("t4");

    // T5: reset during bit 4 of 0xFF, then 0x5A
    rxd = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b1;
      cyc(BIT);
    end
    cyc(BIT / 2);
    rstn = 1'b0;
    cyc(1);
    check("t5_rst_busy", 32'(rx_busy), 32'd0);
    check("t5_rst_data", 32'(rx_data), 32'd0);
    rstn = 1'b1;
    cyc(5 * BIT);
    check("t5_no_deliver", 32'(rx_valid), 32'd0);
    send_frame(8'h5A, 1'b1);
    recv("t5");
    do_ack("t5");
    cyc(BIT);

    // T6: TX-style stream with ack on each byte
    f0 = ferr_hi;
    o0 = ovr_hi;
    for (int k = 0; k < 3; k++) begin
      send_frame(t6[k], 1'b1);
      recv($sformatf("t6_%0d", k));
      do_ack($sformatf("t6_%0d", k));
      cyc(BIT);
    end
    check("t6_ferr", 32'(ferr_hi - f0), 32'd0);
    check("t6_ovr", 32'(ovr_hi - o0), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
